// File: rtl/inert_intf.sv
// inert_intf: SPI sequencer that configures the inertial sensor, then reads five
// signed 16-bit readings on every data-ready interrupt and pulses vld.
module inert_intf #(
   parameter int TMR_WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               INT,
   input  logic               done,
   input  logic [15:0]        rd_data,
   output logic               wrt,
   output logic [15:0]        cmd,
   output logic               vld,
   output logic signed [15:0] ptch_rt,
   output logic signed [15:0] roll_rt,
   output logic signed [15:0] yaw_rt,
   output logic signed [15:0] ax,
   output logic signed [15:0] ay
);
   typedef enum logic [2:0] {PWR_WAIT, INIT, WAIT_INT, READ, UPDATE} state_t;
   state_t state;
   logic [TMR_WIDTH-1:0] tmr;
   logic [3:0] idx, nxt;
   logic [7:0] b [10];
   logic int_ff1, int_ff2;
   logic unused_hi;
   assign nxt = idx + 4'd1;
   assign unused_hi = ^rd_data[15:8];
   // idx 0-3 are config writes; idx 4-13 read registers 0x22..0x2B
   function automatic logic [15:0] cmd_of(input logic [3:0] i);
      return (i == 4'd0) ? 16'h0D02 :
             (i == 4'd1) ? 16'h1062 :
             (i == 4'd2) ? 16'h1162 :
             (i == 4'd3) ? 16'h1460 : {8'h9E + {4'd0, i}, 8'h00};
   endfunction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         int_ff1 <= 1'b0;
         int_ff2 <= 1'b0;
      end else begin
         int_ff1 <= INT;
         int_ff2 <= int_ff1;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= PWR_WAIT;
         tmr     <= '0;
         idx     <= '0;
         b       <= '{default: '0};
         wrt     <= 1'b0;
         vld     <= 1'b0;
         cmd     <= '0;
         ptch_rt <= '0;
         roll_rt <= '0;
         yaw_rt  <= '0;
         ax      <= '0;
         ay      <= '0;
      end else begin
         wrt <= 1'b0;
         vld <= 1'b0;
         case (state)
            PWR_WAIT: begin
               tmr <= tmr + 1'b1;
               if (&tmr) begin
                  wrt   <= 1'b1;
                  idx   <= 4'd0;
                  cmd   <= cmd_of(4'd0);
                  state <= INIT;
               end
            end
            INIT: if (done) begin
               if (idx < 4'd3) begin
                  idx <= nxt;
                  wrt <= 1'b1;
                  cmd <= cmd_of(nxt);
               end else begin
                  idx   <= 4'd4;
                  state <= WAIT_INT;
               end
            end
            WAIT_INT: if (int_ff2) begin
               wrt   <= 1'b1;
               cmd   <= cmd_of(idx);
               state <= READ;
            end
            READ: if (done) begin
               b[idx - 4'd4] <= rd_data[7:0];
               if (idx < 4'd13) begin
                  idx <= nxt;
                  wrt <= 1'b1;
                  cmd <= cmd_of(nxt);
               end else
                  state <= UPDATE;
            end
            UPDATE: begin
               ptch_rt <= {b[1], b[0]};
               roll_rt <= {b[3], b[2]};
               yaw_rt  <= {b[5], b[4]};
               ax      <= {b[7], b[6]};
               ay      <= {b[9], b[8]};
               vld     <= 1'b1;
               idx     <= 4'd4;
               state   <= WAIT_INT;
            end
            default: state <= PWR_WAIT;
         endcase
      end
   end
endmodule

// File: tb/tb_inert_intf.sv
// tb_inert_intf: directed bench for inert_intf with a behavioural SPI slave that
// answers each wrt with done 8 clocks later and logs every transaction.
module tb_inert_intf;
   logic clk = 1'b0, rst_n = 1'b0, INT = 1'b0, done = 1'b0;
   logic [15:0] rd_data = '0;
   logic wrt, vld;
   logic [15:0] cmd;
   logic signed [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;
   int n_chk = 0, n_fail = 0;
   int cyc = 0, pend = 0, wrt_cnt = 0, done_cnt = 0, vld_cnt = 0, viol = 0, wide = 0;
   int wrt_cyc [256];
   int done_cyc [256];
   int vld_cyc [256];
   logic [15:0] cmd_log [256];
   logic [7:0] q [$];
   logic vld_q = 1'b0, dn = 1'b0;

   inert_intf #(.TMR_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
      .wrt(wrt), .cmd(cmd), .vld(vld), .ptch_rt(ptch_rt), .roll_rt(roll_rt),
      .yaw_rt(yaw_rt), .ax(ax), .ay(ay)
   );

   always #5 clk = ~clk;

   // SPI slave model and transaction logger, acting mid-cycle
   always @(negedge clk) begin
      cyc++;
      dn = 1'b0;
      if (!rst_n) pend = 0;
      else if (pend > 0) begin
         pend--;
         dn = (pend == 0);
      end
      if (wrt === 1'b1) begin
         if (pend > 0 || dn) viol++;
         wrt_cyc[wrt_cnt] = cyc;
         cmd_log[wrt_cnt] = cmd;
         wrt_cnt++;
         pend = 8;
      end
      if (dn) begin
         done_cyc[done_cnt] = cyc;
         done_cnt++;
         if (q.size() > 0) rd_data = {8'($urandom), q.pop_front()};
         else rd_data = 16'($urandom);
      end else
         rd_data = 16'($urandom);
      done = dn;
      if (vld === 1'b1) begin
         if (vld_q) wide++;
         vld_cyc[vld_cnt] = cyc;
         vld_cnt++;
      end
      vld_q = (vld === 1'b1);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int cnt_of(input int which);
      return (which == 0) ? wrt_cnt : (which == 1) ? done_cnt : vld_cnt;
   endfunction

   task automatic wait_cnt(input int which, input int target, input int lim, output bit ok);
      int n = 0;
      while (cnt_of(which) < target && n < lim) begin
         tick();
         n++;
      end
      ok = cnt_of(which) >= target;
   endtask

   function automatic logic [79:0] readings();
      return {ptch_rt, roll_rt, yaw_rt, ax, ay};
   endfunction

   task automatic wait_first_wrt(output int n);
      int w0 = wrt_cnt;
      n = 0;
      while (wrt_cnt == w0 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      INT = 1'b1;
      repeat (2) tick();
      n_chk++;
      if (wrt !== 1'b0) begin n_fail++; $display("FAIL reset_wrt: got %b required 0", wrt); end
      n_chk++;
      if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b required 0", vld); end
      n_chk++;
      if (readings() !== 80'h0) begin n_fail++; $display("FAIL reset_readings: got %h required 0", readings()); end
      INT = 1'b0;
      rst_n = 1'b1;
      wait_first_wrt(n);
      n_chk++;
      if (n !== 16) begin n_fail++; $display("FAIL powerup_delay: first wrt after %0d clocks, required 16", n); end
   endtask

   task automatic test_init();
      int w0 = wrt_cnt - 1, d0 = done_cnt;
      bit ok;
      logic [15:0] exp [4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};
      wait_cnt(1, d0 + 4, 200, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL init_done_timeout: got %0d dones required 4", done_cnt - d0); end
      repeat (30) tick();
      n_chk++;
      if (wrt_cnt - w0 !== 4) begin n_fail++; $display("FAIL init_wrt_count: got %0d required 4", wrt_cnt - w0); end
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (cmd_log[w0 + i] !== exp[i]) begin n_fail++; $display("FAIL init_cmd%0d: got %h required %h", i, cmd_log[w0 + i], exp[i]); end
      end
      for (int i = 1; i < 4; i++) begin
         n_chk++;
         if (wrt_cyc[w0 + i] - done_cyc[d0 + i - 1] !== 1) begin
            n_fail++;
            $display("FAIL init_gap%0d: got %0d clocks required 1", i, wrt_cyc[w0 + i] - done_cyc[d0 + i - 1]);
         end
      end
      n_chk++;
      if (vld_cnt !== 0) begin n_fail++; $display("FAIL init_no_vld: got %0d required 0", vld_cnt); end
   endtask

   task automatic test_read();
      int w0 = wrt_cnt, d0 = done_cnt, v0 = vld_cnt, c0;
      bit ok;
      logic [7:0] bs [10] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'h00};
      foreach (bs[i]) q.push_back(bs[i]);
      c0 = cyc;
      INT = 1'b1;
      wait_cnt(0, w0 + 1, 20, ok);
      INT = 1'b0;
      n_chk++;
      if (!ok || wrt_cyc[w0] - c0 !== 3) begin n_fail++; $display("FAIL int_to_wrt: got %0d clocks required 3", ok ? wrt_cyc[w0] - c0 : -1); end
      wait_cnt(2, v0 + 1, 400, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL read_vld_timeout: got %0d vld required 1", vld_cnt - v0); end
      n_chk++;
      if (readings() !== {16'h1234, 16'hABCD, 16'h8001, 16'h7FFF, 16'h0000}) begin
         n_fail++;
         $display("FAIL read_values: got %h required 1234abcd80017fff0000", readings());
      end
      n_chk++;
      if (roll_rt !== -16'sd21555) begin n_fail++; $display("FAIL read_roll_signed: got %0d required -21555", roll_rt); end
      repeat (30) tick();
      for (int i = 0; i < 10; i++) begin
         n_chk++;
         if (cmd_log[w0 + i] !== 16'hA200 + 16'(i * 256)) begin
            n_fail++;
            $display("FAIL read_cmd%0d: got %h required %h", i, cmd_log[w0 + i], 16'hA200 + 16'(i * 256));
         end
      end
      n_chk++;
      if (vld_cyc[v0] - done_cyc[d0 + 9] !== 2) begin n_fail++; $display("FAIL read_vld_latency: got %0d required 2", vld_cyc[v0] - done_cyc[d0 + 9]); end
      n_chk++;
      if (vld_cnt - v0 !== 1 || wrt_cnt - w0 !== 10) begin
         n_fail++;
         $display("FAIL read_counts: got vld %0d wrt %0d required 1 and 10", vld_cnt - v0, wrt_cnt - w0);
      end
      n_chk++;
      if (viol !== 0 || wide !== 0) begin n_fail++; $display("FAIL protocol: got %0d overlaps %0d wide vld required 0", viol, wide); end
   endtask

   task automatic test_hold();
      logic [79:0] snap = readings(), exp;
      logic [7:0] bs [10];
      int v0 = vld_cnt, w0 = wrt_cnt, bad = 0, n = 0;
      bit ok;
      repeat (20) tick();
      n_chk++;
      if (readings() !== snap) begin n_fail++; $display("FAIL hold_idle: got %h required %h", readings(), snap); end
      foreach (bs[i]) begin
         bs[i] = 8'($urandom);
         q.push_back(bs[i]);
      end
      exp = {bs[1], bs[0], bs[3], bs[2], bs[5], bs[4], bs[7], bs[6], bs[9], bs[8]};
      INT = 1'b1;
      wait_cnt(0, w0 + 1, 20, ok);
      INT = 1'b0;
      while (vld_cnt == v0 && n < 400) begin
         if (readings() !== snap) bad++;
         tick();
         n++;
      end
      n_chk++;
      if (bad !== 0) begin n_fail++; $display("FAIL hold_burst: outputs changed in %0d cycles before vld, required 0", bad); end
      n_chk++;
      if (vld_cnt - v0 !== 1 || readings() !== exp) begin
         n_fail++;
         $display("FAIL hold_update: got vld %0d values %h required 1 and %h", vld_cnt - v0, readings(), exp);
      end
   endtask

   task automatic test_back_to_back();
      int w0 = wrt_cnt, v0 = vld_cnt;
      bit ok1, ok2, ok3;
      logic [7:0] bs [20];
      logic [79:0] exp;
      foreach (bs[i]) begin
         bs[i] = 8'(i * 37 + 5);
         q.push_back(bs[i]);
      end
      exp = {bs[11], bs[10], bs[13], bs[12], bs[15], bs[14], bs[17], bs[16], bs[19], bs[18]};
      INT = 1'b1;
      wait_cnt(2, v0 + 1, 400, ok1);
      wait_cnt(0, w0 + 11, 20, ok2);
      INT = 1'b0;
      n_chk++;
      if (!ok1 || !ok2 || wrt_cyc[w0 + 10] - vld_cyc[v0] !== 1) begin
         n_fail++;
         $display("FAIL b2b_restart: got %0d clocks vld to wrt required 1", (ok1 && ok2) ? wrt_cyc[w0 + 10] - vld_cyc[v0] : -1);
      end
      wait_cnt(2, v0 + 2, 400, ok3);
      repeat (40) tick();
      n_chk++;
      if (!ok3 || vld_cnt - v0 !== 2 || wrt_cnt - w0 !== 20) begin
         n_fail++;
         $display("FAIL b2b_counts: got vld %0d wrt %0d required 2 and 20", vld_cnt - v0, wrt_cnt - w0);
      end
      n_chk++;
      if (readings() !== exp) begin n_fail++; $display("FAIL b2b_values: got %h required %h", readings(), exp); end
   endtask

   task automatic test_reset_mid();
      int d0 = done_cnt, v0 = vld_cnt, w0, n;
      bit ok;
      logic [15:0] exp [4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};
      for (int i = 0; i < 10; i++) q.push_back(8'(8'hA0 + i));
      INT = 1'b1;
      wait_cnt(1, d0 + 5, 200, ok);
      INT = 1'b0;
      rst_n = 1'b0;
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL mid_done_timeout: got %0d dones required 5", done_cnt - d0); end
      tick();
      n_chk++;
      if (readings() !== 80'h0 || vld !== 1'b0 || wrt !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got %h vld %b wrt %b required all 0", readings(), vld, wrt);
      end
      tick();
      q.delete();
      w0 = wrt_cnt;
      rst_n = 1'b1;
      wait_first_wrt(n);
      n_chk++;
      if (n !== 16) begin n_fail++; $display("FAIL mid_powerup_delay: first wrt after %0d clocks, required 16", n); end
      wait_cnt(0, w0 + 4, 200, ok);
      repeat (20) tick();
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (cmd_log[w0 + i] !== exp[i]) begin n_fail++; $display("FAIL mid_init_cmd%0d: got %h required %h", i, cmd_log[w0 + i], exp[i]); end
      end
      n_chk++;
      if (vld_cnt !== v0 || wrt_cnt - w0 !== 4) begin
         n_fail++;
         $display("FAIL mid_counts: got vld %0d wrt %0d required 0 and 4", vld_cnt - v0, wrt_cnt - w0);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_read();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
